// File: rtl/vehicle_status_monitor.sv
// Vehicle status flag producer: debounced thermal and fuel flags with hysteresis,
// plus trip-distance tracking. Every output comes straight from a flop.
module vehicle_status_monitor #(
  parameter int TEMP_W     = 8,
  parameter int TEMP_HOT   = 85,
  parameter int TEMP_COOL  = 75,
  parameter int FUEL_W     = 8,
  parameter int FUEL_EMPTY = 4,
  parameter int DIST_W     = 16,
  parameter int DEBOUNCE   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic              fuel_valid,
  input  logic [FUEL_W-1:0] fuel_level,
  input  logic              odo_tick,
  input  logic              trip_load,
  input  logic [DIST_W-1:0] trip_target,
  output logic              cpu_overheated,
  output logic              gas_tank_empty,
  output logic              arrived,
  output logic              trip_active,
  output logic [DIST_W-1:0] dist_remaining
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TEMP_W-1:0] HOT_TH   = TEMP_W'(TEMP_HOT);
  localparam logic [TEMP_W-1:0] COOL_TH  = TEMP_W'(TEMP_COOL);
  localparam logic [FUEL_W-1:0] EMPTY_TH = FUEL_W'(FUEL_EMPTY);
  localparam logic [DIST_W-1:0] DIST_ONE = DIST_W'(1);

  typedef enum logic {TH_COOL, TH_HOT} therm_state_e;
  typedef enum logic {FU_OK, FU_EMPTY} fuel_state_e;
  typedef enum logic [1:0] {TR_IDLE, TR_ACTIVE, TR_ARRIVED} trip_state_e;

  therm_state_e      therm_q, therm_d;
  fuel_state_e       fuel_q, fuel_d;
  trip_state_e       trip_q, trip_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              cpu_overheated_q, cpu_overheated_d;
  logic              gas_tank_empty_q, gas_tank_empty_d;
  logic              arrived_q, arrived_d;
  logic              trip_active_q, trip_active_d;
  logic              t_qual, f_qual;

  // A sample "qualifies" when it argues for leaving the current state; the
  // band between the two thresholds qualifies in neither, giving hysteresis.
  always_comb begin
    therm_d          = therm_q;
    tcnt_d           = tcnt_q;
    cpu_overheated_d = cpu_overheated_q;
    t_qual = (therm_q == TH_COOL) ? (temp_data >= HOT_TH) : (temp_data <= COOL_TH);
    if (temp_valid) begin
      if (!t_qual) begin
        tcnt_d = '0;
      end else if (tcnt_q == DEB_LAST) begin
        tcnt_d           = '0;
        therm_d          = (therm_q == TH_COOL) ? TH_HOT : TH_COOL;
        cpu_overheated_d = (therm_q == TH_COOL);
      end else begin
        tcnt_d = tcnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    fuel_d           = fuel_q;
    fcnt_d           = fcnt_q;
    gas_tank_empty_d = gas_tank_empty_q;
    f_qual = (fuel_q == FU_OK) ? (fuel_level <= EMPTY_TH) : (fuel_level > EMPTY_TH);
    if (fuel_valid) begin
      if (!f_qual) begin
        fcnt_d = '0;
      end else if (fcnt_q == DEB_LAST) begin
        fcnt_d           = '0;
        fuel_d           = (fuel_q == FU_OK) ? FU_EMPTY : FU_OK;
        gas_tank_empty_d = (fuel_q == FU_OK);
      end else begin
        fcnt_d = fcnt_q + CNT_ONE;
      end
    end
  end

  // A load always wins over a simultaneous tick; ticks only count while ACTIVE,
  // and ACTIVE always has at least one unit left, so the counter cannot wrap.
  always_comb begin
    trip_d        = trip_q;
    dist_d        = dist_q;
    arrived_d     = arrived_q;
    trip_active_d = trip_active_q;
    if (trip_load) begin
      if (trip_target == '0) begin
        trip_d        = TR_ARRIVED;
        dist_d        = '0;
        arrived_d     = 1'b1;
        trip_active_d = 1'b0;
      end else begin
        trip_d        = TR_ACTIVE;
        dist_d        = trip_target;
        arrived_d     = 1'b0;
        trip_active_d = 1'b1;
      end
    end else if (trip_q == TR_ACTIVE && odo_tick) begin
      dist_d = dist_q - DIST_ONE;
      if (dist_q == DIST_ONE) begin
        trip_d        = TR_ARRIVED;
        arrived_d     = 1'b1;
        trip_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      therm_q          <= TH_COOL;
      tcnt_q           <= '0;
      cpu_overheated_q <= 1'b0;
      fuel_q           <= FU_EMPTY;
      fcnt_q           <= '0;
      gas_tank_empty_q <= 1'b1;
      trip_q           <= TR_IDLE;
      dist_q           <= '0;
      arrived_q        <= 1'b0;
      trip_active_q    <= 1'b0;
    end else begin
      therm_q          <= therm_d;
      tcnt_q           <= tcnt_d;
      cpu_overheated_q <= cpu_overheated_d;
      fuel_q           <= fuel_d;
      fcnt_q           <= fcnt_d;
      gas_tank_empty_q <= gas_tank_empty_d;
      trip_q           <= trip_d;
      dist_q           <= dist_d;
      arrived_q        <= arrived_d;
      trip_active_q    <= trip_active_d;
    end
  end

  assign cpu_overheated = cpu_overheated_q;
  assign gas_tank_empty = gas_tank_empty_q;
  assign arrived        = arrived_q;
  assign trip_active    = trip_active_q;
  assign dist_remaining = dist_q;

endmodule

// File: tb/tb_vehicle_status_monitor.sv
// Bench for vehicle_status_monitor: directed vector table followed by
// randomized traffic compared against a sample-history reference model.
module tb_vehicle_status_monitor;

  localparam int DEB        = 4;
  localparam int TEMP_HOT   = 85;
  localparam int TEMP_COOL  = 75;
  localparam int FUEL_EMPTY = 4;

  logic        clk;
  logic        rst_n;
  logic        temp_valid;
  logic [7:0]  temp_data;
  logic        fuel_valid;
  logic [7:0]  fuel_level;
  logic        odo_tick;
  logic        trip_load;
  logic [15:0] trip_target;
  logic        cpu_overheated;
  logic        gas_tank_empty;
  logic        arrived;
  logic        trip_active;
  logic [15:0] dist_remaining;

  vehicle_status_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .temp_valid     (temp_valid),
    .temp_data      (temp_data),
    .fuel_valid     (fuel_valid),
    .fuel_level     (fuel_level),
    .odo_tick       (odo_tick),
    .trip_load      (trip_load),
    .trip_target    (trip_target),
    .cpu_overheated (cpu_overheated),
    .gas_tank_empty (gas_tank_empty),
    .arrived        (arrived),
    .trip_active    (trip_active),
    .dist_remaining (dist_remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        tv;
    logic [7:0]  td;
    logic        fv;
    logic [7:0]  fl;
    logic        odo;
    logic        ld;
    logic [15:0] tgt;
    logic        e_oh;
    logic        e_empty;
    logic        e_arr;
    logic        e_act;
    logic [15:0] e_rem;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Reference model: recent valid samples since the last flag change, and the
  // trip as target minus ticks counted since the last load.
  bit m_hot;
  bit m_empty;
  int t_hist[$];
  int f_hist[$];
  bit m_started;
  int m_target;
  int m_ticks;

  function automatic bit t_qual(input int s, input bit hot);
    return hot ? (s <= TEMP_COOL) : (s >= TEMP_HOT);
  endfunction

  function automatic bit f_qual(input int s, input bit empty);
    return empty ? (s > FUEL_EMPTY) : (s <= FUEL_EMPTY);
  endfunction

  task automatic model_reset();
    m_hot     = 1'b0;
    m_empty   = 1'b1;
    t_hist.delete();
    f_hist.delete();
    m_started = 1'b0;
    m_target  = 0;
    m_ticks   = 0;
  endtask

  task automatic model_step();
    int run;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (temp_valid) begin
      t_hist.push_back(int'(temp_data));
      if (t_hist.size() > DEB) void'(t_hist.pop_front());
      run = 0;
      for (int k = t_hist.size() - 1; k >= 0; k--) begin
        if (!t_qual(t_hist[k], m_hot)) break;
        run++;
      end
      if (run >= DEB) begin
        m_hot = !m_hot;
        t_hist.delete();
      end
    end
    if (fuel_valid) begin
      f_hist.push_back(int'(fuel_level));
      if (f_hist.size() > DEB) void'(f_hist.pop_front());
      run = 0;
      for (int k = f_hist.size() - 1; k >= 0; k--) begin
        if (!f_qual(f_hist[k], m_empty)) break;
        run++;
      end
      if (run >= DEB) begin
        m_empty = !m_empty;
        f_hist.delete();
      end
    end
    if (trip_load) begin
      m_started = 1'b1;
      m_target  = int'(trip_target);
      m_ticks   = 0;
    end else if (odo_tick && m_started && m_ticks < m_target) begin
      m_ticks++;
    end
  endtask

  task automatic add_vec(input logic r, input logic tv, input int td, input logic fv,
                         input int fl, input logic odo, input logic ld, input int tgt,
                         input logic eoh, input logic eem, input logic ear,
                         input logic eac, input int erem);
    vec_t v;
    v.rst_n = r;   v.tv = tv;   v.td = 8'(td);   v.fv = fv;  v.fl = 8'(fl);
    v.odo = odo;   v.ld = ld;   v.tgt = 16'(tgt);
    v.e_oh = eoh;  v.e_empty = eem;  v.e_arr = ear;  v.e_act = eac;
    v.e_rem = 16'(erem);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n       = v.rst_n;
    temp_valid  = v.tv;
    temp_data   = v.td;
    fuel_valid  = v.fv;
    fuel_level  = v.fl;
    odo_tick    = v.odo;
    trip_load   = v.ld;
    trip_target = v.tgt;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s %s actual=%0d required=%0d", name, field, act, exp);
  endtask

  task automatic checkOutput(input string name, input logic eoh, input logic eem,
                             input logic ear, input logic eac, input logic [15:0] erem);
    cmp(name, "cpu_overheated", 16'(cpu_overheated), 16'(eoh));
    cmp(name, "gas_tank_empty", 16'(gas_tank_empty), 16'(eem));
    cmp(name, "arrived",        16'(arrived),        16'(ear));
    cmp(name, "trip_active",    16'(trip_active),    16'(eac));
    cmp(name, "dist_remaining", dist_remaining,      erem);
  endtask

  initial begin
    vec_t v;
    int   t_regime;
    int   f_regime;
    model_reset();

    // Reset with busy inputs
    add_vec(0, 1, 200, 1, 100, 1, 1, 9,   0, 1, 0, 0, 0);
    add_vec(0, 1, 200, 1, 100, 1, 1, 9,   0, 1, 0, 0, 0);
    // Thermal: 90,90,90,70,90,90,90,90 with gaps
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 0, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 70, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 0, 0,  0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 0, 0,  0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) add_vec(1, 1, 80, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(1, 1, 70, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add_vec(1, 1, 70, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0);
    // Fuel: 50 x4 clears, then 4,4,5,(gap),4,4,4,4 sets on the last
    for (int i = 0; i < 3; i++) add_vec(1, 0, 0, 1, 50, 0, 0, 0, 0, 1, 0, 0, 0);
    add_vec(1, 0, 0, 1, 50, 0, 0, 0,      0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4,  0, 0, 0,      0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4,  0, 0, 0,      0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 5,  0, 0, 0,      0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0,  0, 0, 0,      0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4,  0, 0, 0,      0, 1, 0, 0, 0);
    // Trip: load 3, three ticks, extra ticks ignored
    add_vec(1, 0, 0, 0, 0, 0, 1, 3,       0, 1, 0, 1, 3);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 0, 1, 2);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 0, 1, 1);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 1, 0, 0);
    // Collisions: load wins over tick; load of zero arrives at once
    add_vec(1, 0, 0, 0, 0, 0, 1, 5,       0, 1, 0, 1, 5);
    add_vec(1, 0, 0, 0, 0, 1, 1, 10,      0, 1, 0, 1, 10);
    add_vec(1, 0, 0, 0, 0, 1, 0, 0,       0, 1, 0, 1, 9);
    add_vec(1, 0, 0, 0, 0, 1, 1, 0,       0, 1, 1, 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0);
    // Mid-operation reset while HOT with 7 remaining
    add_vec(1, 1, 90, 0, 0, 0, 1, 7,      0, 1, 0, 1, 7);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 1, 7);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      0, 1, 0, 1, 7);
    add_vec(1, 1, 90, 0, 0, 0, 0, 0,      1, 1, 0, 1, 7);
    add_vec(0, 1, 90, 0, 0, 1, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 0, 0,  0, 0, 1, 0, 0,      0, 1, 0, 0, 0);
    add_vec(1, 0, 0,  0, 0, 1, 0, 0,      0, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_oh, vecs[i].e_empty,
                  vecs[i].e_arr, vecs[i].e_act, vecs[i].e_rem);
    end

    // Randomized traffic in biased regimes so both flags actually toggle
    t_regime = 0;
    f_regime = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        t_regime = int'($urandom_range(0, 2));
        f_regime = int'($urandom_range(0, 2));
      end
      v.rst_n = !(i < 2 || $urandom_range(0, 199) == 0);
      v.tv    = ($urandom_range(0, 9) < 7);
      case (t_regime)
        0:       v.td = 8'($urandom_range(0, 9) < 8 ? $urandom_range(85, 110) : $urandom_range(60, 84));
        1:       v.td = 8'($urandom_range(0, 9) < 8 ? $urandom_range(40, 75) : $urandom_range(76, 100));
        default: v.td = 8'($urandom_range(70, 90));
      endcase
      v.fv    = ($urandom_range(0, 9) < 7);
      case (f_regime)
        0:       v.fl = 8'($urandom_range(0, 9) < 8 ? $urandom_range(0, 4) : $urandom_range(5, 60));
        1:       v.fl = 8'($urandom_range(0, 9) < 8 ? $urandom_range(5, 255) : $urandom_range(0, 4));
        default: v.fl = 8'($urandom_range(2, 7));
      endcase
      v.odo   = $urandom_range(0, 1) == 1;
      v.ld    = $urandom_range(0, 19) == 0;
      v.tgt   = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 65535) : $urandom_range(0, 8));
      v.e_oh = 1'b0; v.e_empty = 1'b0; v.e_arr = 1'b0; v.e_act = 1'b0; v.e_rem = '0;
      applyStimulus(v);
      checkOutput("rand", m_hot, m_empty, m_started && (m_target == m_ticks),
                  m_started && (m_target > m_ticks),
                  m_started ? 16'(m_target - m_ticks) : 16'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
